pico_port_bridge: RTL and testbench
===================================

Name: pico_port_bridge

Overview:
- Parametrised I/O bridge between a KCPSM3-style port bus and the speech-synthesizer datapath. It replaces ad-hoc per-design port decoding.
- Provides N registered input channels, N output registers, a sample FIFO with valid/ready drain, a done pulse, sticky event capture and an interrupt request/acknowledge handshake.
- Sits between the soft-processor core and the address/audio logic.

Parameters:
- DATA_W, 8, port data width (in_port/out_port).
- NUM_IN, 4, input channels, decoded at IN_BASE+i.
- NUM_OUT, 4, output registers, decoded at OUT_BASE+i.
- NUM_EV, 4, event inputs (1..5).
- FIFO_DEPTH, 16, sample FIFO entries (power of two, >=2).
- IN_BASE, 8'h00, first input-channel port_id.
- OUT_BASE, 8'h80, first output-register port_id.
- STATUS_ADDR, 8'h10, read-only status port.
- CLEAR_ADDR, 8'h50, write-only event/overflow clear port.
- DONE_ADDR, 8'h40, write-only done-pulse port.
- FIFO_ADDR, 8'hC0, write-only FIFO push port.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- port_id  in  8  processor port address
- out_port  in  DATA_W  processor write data
- write_strobe  in  1  write qualifier, one cycle
- read_strobe  in  1  read qualifier (ignored for decode; reads are side-effect free)
- in_port  out  DATA_W  registered read data to processor
- interrupt  out  1  interrupt request
- interrupt_ack  in  1  processor acknowledge
- in_ch  in  NUM_IN*DATA_W  packed input channels; channel i at bits [i*DATA_W +: DATA_W]
- out_reg  out  NUM_OUT*DATA_W  packed output registers
- ev_in  in  NUM_EV  event inputs, rising-edge sensitive
- done_pulse  out  1  one-cycle pulse
- smp_data  out  DATA_W  FIFO head
- smp_valid  out  1  FIFO non-empty
- smp_ready  in  1  downstream accept

Behaviour:
- Reset values: in_port=0, interrupt=0, out_reg=0, done_pulse=0, smp_valid=0, FIFO pointers=0, pending=0, overflow=0, edge detectors loaded with 0.
  - Reset mid-operation discards FIFO contents and any pending interrupt.
- Read mux latency is 1 cycle: in_port registered from the port_id of the previous cycle.
  - port_id = IN_BASE+i (i<NUM_IN) returns in_ch[i].
  - port_id = STATUS_ADDR returns {pending[NUM_EV-1:0] in bits[7:3], overflow bit2, empty bit1, full bit0}; unused bits 0.
  - Any other port_id returns 0.
- Writes take effect only on cycles with write_strobe=1. Exact 8-bit compare on port_id.
  - OUT_BASE+i: out_reg[i] <= out_port.
  - DONE_ADDR: done_pulse=1 on the next cycle only. Back-to-back writes give back-to-back pulses.
  - CLEAR_ADDR: pending[k] cleared where out_port[k]=1; overflow cleared if out_port[7]=1.
  - FIFO_ADDR: push out_port. If full, the push is dropped and overflow is set (sticky).
- FIFO:
  - smp_data/smp_valid reflect the head; pop occurs when smp_valid & smp_ready.
  - Simultaneous push and pop when full: pop and push both succeed, no overflow.
  - Simultaneous push and pop when empty: push only; valid the next cycle (first-word latency 1).
  - Pointers wrap modulo FIFO_DEPTH; an extra count bit distinguishes full from empty.
- Events:
  - A rising edge on ev_in[k] (registered prev 0, current 1) sets pending[k].
  - A set on the same cycle as a clear of the same bit: set wins.
- Interrupt state machine IDLE -> REQ -> IDLE:
  - IDLE -> REQ when any new event sets a pending bit (edge detected this cycle); interrupt=1 from the next cycle.
  - REQ holds interrupt=1 until interrupt_ack=1 is sampled. interrupt=0 on the next cycle, state IDLE.
  - Pending bits already set do not re-request; only new edges do.
  - New edge on the same cycle as ack: the ack is honoured (one cycle low), then the state re-enters REQ.
  - interrupt_ack while IDLE is ignored.

Optional Feature:
- Macro PICO_PORT_BRIDGE_FIFO_EN.
- Defined: sample buffer is a FIFO_DEPTH-entry FIFO as above.
- Undefined: single-entry holding register (effective depth 1).
  - full = smp_valid.
  - Push when full and not popping this cycle sets overflow.
  - Push and pop on the same cycle succeed.
  - FIFO_DEPTH is ignored.
  - All other behaviour is identical.

Test Plan:
1. Reset, then drive in_ch ch2=8'hA5 and port_id=8'h02 -> in_port=8'hA5 exactly 1 cycle later. STATUS read -> 8'h02 (empty).
2. Write 8'h3C to port 8'h81 and 8'h7E to 8'h40 -> out_reg[1]=8'h3C; done_pulse high for exactly one cycle.
3. Hold smp_ready=0 and push 17 bytes 0..16 -> full after 16; 17th byte dropped; STATUS bit2=1. Release ready -> smp_data 0..15 in order, then valid=0. Write 8'h80 to CLEAR_ADDR -> overflow=0.
4. Rising edge on ev_in[1] -> interrupt=1 the next cycle; STATUS bits[7:3]=5'b00010. Ack -> interrupt=0 the next cycle. Write 8'h02 to CLEAR_ADDR -> pending=0.
5. Edge on ev_in[0] coincident with interrupt_ack while in REQ -> interrupt low one cycle, then high again.
6. Assert reset with FIFO holding 5 entries and interrupt=1 -> next cycle smp_valid=0, interrupt=0, STATUS=8'h02. Repeat scenario 3 without PICO_PORT_BRIDGE_FIFO_EN -> second push with ready=0 sets overflow.

Source files
------------

// File: rtl/pico_port_bridge_if.sv
// Port-bus and sample-stream signal bundle between the soft-processor side and pico_port_bridge.
interface pico_port_bridge_if #(
    parameter int unsigned DATA_W = 8
);
    logic [7:0]        port_id;
    logic [DATA_W-1:0] out_port;
    logic              write_strobe;
    logic              read_strobe;
    logic [DATA_W-1:0] in_port;
    logic              interrupt;
    logic              interrupt_ack;
    logic [DATA_W-1:0] smp_data;
    logic              smp_valid;
    logic              smp_ready;

    modport master (
        output port_id, out_port, write_strobe, read_strobe, interrupt_ack, smp_ready,
        input  in_port, interrupt, smp_data, smp_valid
    );

    modport slave (
        input  port_id, out_port, write_strobe, read_strobe, interrupt_ack, smp_ready,
        output in_port, interrupt, smp_data, smp_valid
    );
endinterface

// File: rtl/pico_port_bridge.sv
// KCPSM3-style port decoder: input channels, output registers, sample buffer, events and IRQ.
// Define PICO_PORT_BRIDGE_FIFO_EN for a FIFO_DEPTH-entry sample FIFO; otherwise a single holding register.
module pico_port_bridge #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_IN      = 4,
    parameter int unsigned NUM_OUT     = 4,
    parameter int unsigned NUM_EV      = 4,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [7:0]  IN_BASE     = 8'h00,
    parameter logic [7:0]  OUT_BASE    = 8'h80,
    parameter logic [7:0]  STATUS_ADDR = 8'h10,
    parameter logic [7:0]  CLEAR_ADDR  = 8'h50,
    parameter logic [7:0]  DONE_ADDR   = 8'h40,
    parameter logic [7:0]  FIFO_ADDR   = 8'hC0
) (
    input  logic                      clk,
    input  logic                      reset,
    pico_port_bridge_if.slave         bus,
    input  logic [NUM_IN*DATA_W-1:0]  in_ch,
    output logic [NUM_OUT*DATA_W-1:0] out_reg,
    input  logic [NUM_EV-1:0]         ev_in,
    output logic                      done_pulse
);
    typedef enum logic {IDLE, REQ} state_e;

    state_e                    state_q, state_d;
    logic                      irq_q, irq_d;
    logic                      rearm_q, rearm_d;
    logic [DATA_W-1:0]         in_port_q, in_port_d;
    logic [NUM_OUT*DATA_W-1:0] out_reg_q, out_reg_d;
    logic                      done_q, done_d;
    logic [NUM_EV-1:0]         ev_prev_q;
    logic [NUM_EV-1:0]         pending_q, pending_d;
    logic                      ovf_q, ovf_d;
    logic [NUM_EV-1:0]         new_ev;
    logic [NUM_EV-1:0]         clr_mask;
    logic [7:0]                status8;
    logic                      clear_wr;
    logic                      push, pop, push_ok, full, empty;
    logic                      unused_read_strobe;

    // Reads never have side effects, so read_strobe plays no part in decode.
    assign unused_read_strobe = bus.read_strobe;

    assign pop  = bus.smp_valid & bus.smp_ready;
    assign push = bus.write_strobe && (bus.port_id == FIFO_ADDR);
    assign push_ok = push & (~full | pop);

`ifdef PICO_PORT_BRIDGE_FIFO_EN
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign bus.smp_valid = ~empty;
    assign bus.smp_data  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= bus.out_port;
    end
`else
    localparam int unsigned unused_depth = FIFO_DEPTH;

    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;

    assign full  = hold_vld_q;
    assign empty = ~hold_vld_q;
    assign bus.smp_valid = hold_vld_q;
    assign bus.smp_data  = hold_q;

    always_comb begin
        hold_vld_d = push_ok | (hold_vld_q & ~pop);
        hold_d     = push_ok ? bus.out_port : hold_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end
`endif

    always_comb begin
        status8              = '0;
        status8[3 +: NUM_EV] = pending_q;
        status8[2]           = ovf_q;
        status8[1]           = empty;
        status8[0]           = full;
    end

    // Port decode, event capture and interrupt handshake.
    always_comb begin
        in_port_d = '0;
        out_reg_d = out_reg_q;
        state_d   = state_q;
        rearm_d   = rearm_q;

        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (bus.port_id == 8'(IN_BASE + i)) in_port_d = in_ch[i*DATA_W +: DATA_W];
        end
        if (bus.port_id == STATUS_ADDR) in_port_d = DATA_W'(status8);

        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (bus.write_strobe && (bus.port_id == 8'(OUT_BASE + i)))
                out_reg_d[i*DATA_W +: DATA_W] = bus.out_port;
        end

        done_d   = bus.write_strobe && (bus.port_id == DONE_ADDR);
        clear_wr = bus.write_strobe && (bus.port_id == CLEAR_ADDR);
        clr_mask = clear_wr ? bus.out_port[NUM_EV-1:0] : '0;

        new_ev    = ev_in & ~ev_prev_q;
        pending_d = (pending_q & ~clr_mask) | new_ev;
        ovf_d     = (ovf_q & ~(clear_wr & bus.out_port[7])) | (push & full & ~pop);

        // An edge arriving with the ack is remembered so the request re-fires after one low cycle.
        case (state_q)
            IDLE: begin
                if ((|new_ev) || rearm_q) state_d = REQ;
                rearm_d = 1'b0;
            end
            REQ: begin
                if (bus.interrupt_ack) begin
                    state_d = IDLE;
                    rearm_d = |new_ev;
                end
            end
            default: state_d = IDLE;
        endcase
        irq_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            irq_q     <= 1'b0;
            rearm_q   <= 1'b0;
            in_port_q <= '0;
            out_reg_q <= '0;
            done_q    <= 1'b0;
            ev_prev_q <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            rearm_q   <= rearm_d;
            in_port_q <= in_port_d;
            out_reg_q <= out_reg_d;
            done_q    <= done_d;
            ev_prev_q <= ev_in;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_port   = in_port_q;
    assign bus.interrupt = irq_q;
    assign out_reg       = out_reg_q;
    assign done_pulse    = done_q;
endmodule

// File: tb/tb_pico_port_bridge.sv
// Directed, table-driven bench for pico_port_bridge; adapts buffer depth to PICO_PORT_BRIDGE_FIFO_EN.
module tb_pico_port_bridge;
`ifdef PICO_PORT_BRIDGE_FIFO_EN
    localparam int EFF_DEPTH = 16;
`else
    localparam int EFF_DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_ch;
    logic [31:0] out_reg;
    logic [3:0]  ev_in;
    logic        done_pulse;
    int          n_checks = 0;
    int          n_fail   = 0;

    pico_port_bridge_if #(.DATA_W(8)) bus ();

    pico_port_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .in_ch      (in_ch),
        .out_reg    (out_reg),
        .ev_in      (ev_in),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pid;
        logic [7:0]  dout;
        logic        wr;
        logic [7:0]  exp_in;
        logic        exp_done;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd_status(input string name, input logic [7:0] exp);
        bus.write_strobe = 1'b0;
        bus.port_id      = 8'h10;
        step();
        check(name, 32'(bus.in_port), 32'(exp));
    endtask

    task automatic wr_port(input logic [7:0] pid, input logic [7:0] d);
        bus.port_id      = pid;
        bus.out_port     = d;
        bus.write_strobe = 1'b1;
        step();
        bus.write_strobe = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{8'h02, 8'h00, 1'b0, 8'hA5, 1'b0, 32'h0000_0000};
        vecs[1]  = '{8'h00, 8'h00, 1'b0, 8'h11, 1'b0, 32'h0000_0000};
        vecs[2]  = '{8'h03, 8'h00, 1'b0, 8'h44, 1'b0, 32'h0000_0000};
        vecs[3]  = '{8'h10, 8'h00, 1'b0, 8'h02, 1'b0, 32'h0000_0000};
        vecs[4]  = '{8'h04, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0000_0000};
        vecs[5]  = '{8'h81, 8'h3C, 1'b1, 8'h00, 1'b0, 32'h0000_3C00};
        vecs[6]  = '{8'h40, 8'h7E, 1'b1, 8'h00, 1'b1, 32'h0000_3C00};
        vecs[7]  = '{8'h40, 8'h7E, 1'b1, 8'h00, 1'b1, 32'h0000_3C00};
        vecs[8]  = '{8'h83, 8'h5A, 1'b0, 8'h00, 1'b0, 32'h0000_3C00};
        vecs[9]  = '{8'h83, 8'h5A, 1'b1, 8'h00, 1'b0, 32'h5A00_3C00};
        vecs[10] = '{8'h10, 8'h00, 1'b0, 8'h02, 1'b0, 32'h5A00_3C00};
        vecs[11] = '{8'h41, 8'h01, 1'b1, 8'h00, 1'b0, 32'h5A00_3C00};
        vecs[12] = '{8'h80, 8'hFF, 1'b1, 8'h00, 1'b0, 32'h5A00_3CFF};

        reset             = 1'b1;
        in_ch             = 32'h44A5_2211;
        ev_in             = 4'b0000;
        bus.port_id       = 8'h02;
        bus.out_port      = 8'h00;
        bus.write_strobe  = 1'b0;
        bus.read_strobe   = 1'b0;
        bus.interrupt_ack = 1'b0;
        bus.smp_ready     = 1'b0;
        step();
        step();
        check("rst in_port", 32'(bus.in_port), 32'h0);
        check("rst interrupt", 32'(bus.interrupt), 32'h0);
        check("rst out_reg", out_reg, 32'h0);
        check("rst done", 32'(done_pulse), 32'h0);
        check("rst smp_valid", 32'(bus.smp_valid), 32'h0);
        reset = 1'b0;

        // Read mux and write decode vectors.
        for (int i = 0; i < 13; i++) begin
            bus.port_id      = vecs[i].pid;
            bus.out_port     = vecs[i].dout;
            bus.write_strobe = vecs[i].wr;
            bus.read_strobe  = ~vecs[i].wr;
            step();
            check($sformatf("vec%0d in_port", i), 32'(bus.in_port), 32'(vecs[i].exp_in));
            check($sformatf("vec%0d done", i), 32'(done_pulse), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d out_reg", i), out_reg, vecs[i].exp_out);
        end
        bus.write_strobe = 1'b0;
        bus.read_strobe  = 1'b0;

        // Fill past capacity with the sink stalled, then drain in order.
        bus.smp_ready = 1'b0;
        for (int j = 0; j <= EFF_DEPTH; j++) wr_port(8'hC0, 8'(j));
        rd_status("status full+ovf", 8'h05);
        check("head after fill", 32'(bus.smp_data), 32'h0);
        bus.smp_ready = 1'b1;
        for (int j = 0; j < EFF_DEPTH; j++) begin
            check($sformatf("drain%0d valid", j), 32'(bus.smp_valid), 32'h1);
            check($sformatf("drain%0d data", j), 32'(bus.smp_data), 32'(8'(j)));
            step();
        end
        check("drained valid", 32'(bus.smp_valid), 32'h0);
        rd_status("status empty+ovf", 8'h06);
        wr_port(8'h50, 8'h80);
        rd_status("status ovf cleared", 8'h02);

        // Push while draining: first-word latency and concurrent push/pop.
        bus.port_id      = 8'hC0;
        bus.out_port     = 8'hA7;
        bus.write_strobe = 1'b1;
        step();
        check("pass1 valid", 32'(bus.smp_valid), 32'h1);
        check("pass1 data", 32'(bus.smp_data), 32'hA7);
        bus.out_port = 8'hB8;
        step();
        bus.write_strobe = 1'b0;
        check("pass2 valid", 32'(bus.smp_valid), 32'h1);
        check("pass2 data", 32'(bus.smp_data), 32'hB8);
        step();
        check("pass drained", 32'(bus.smp_valid), 32'h0);
        rd_status("pass no ovf", 8'h02);
        bus.smp_ready = 1'b0;

        // Interrupt request / acknowledge.
        ev_in = 4'b0010;
        step();
        check("irq raised", 32'(bus.interrupt), 32'h1);
        rd_status("status pending1", 8'h12);
        check("irq held", 32'(bus.interrupt), 32'h1);
        bus.interrupt_ack = 1'b1;
        step();
        check("irq acked", 32'(bus.interrupt), 32'h0);
        bus.interrupt_ack = 1'b0;
        step();
        check("irq no rereq", 32'(bus.interrupt), 32'h0);
        wr_port(8'h50, 8'h02);
        rd_status("pending cleared", 8'h02);
        bus.interrupt_ack = 1'b1;
        step();
        check("ack idle ignored", 32'(bus.interrupt), 32'h0);
        bus.interrupt_ack = 1'b0;

        // New edge coincident with ack: one low cycle then re-request.
        ev_in = 4'b0110;
        step();
        check("irq ev2", 32'(bus.interrupt), 32'h1);
        ev_in             = 4'b0111;
        bus.interrupt_ack = 1'b1;
        step();
        check("irq ack+edge low", 32'(bus.interrupt), 32'h0);
        bus.interrupt_ack = 1'b0;
        step();
        check("irq rearmed", 32'(bus.interrupt), 32'h1);
        step();
        check("irq rearm held", 32'(bus.interrupt), 32'h1);
        rd_status("status pending 0,2", 8'h2A);

        // Reset mid-operation discards buffer and request.
        for (int j = 0; j < 5; j++) wr_port(8'hC0, 8'(8'h60 + j));
        check("pre-reset valid", 32'(bus.smp_valid), 32'h1);
        check("pre-reset irq", 32'(bus.interrupt), 32'h1);
        reset = 1'b1;
        ev_in = 4'b0000;
        step();
        check("midrst valid", 32'(bus.smp_valid), 32'h0);
        check("midrst irq", 32'(bus.interrupt), 32'h0);
        check("midrst out_reg", out_reg, 32'h0);
        reset = 1'b0;
        rd_status("midrst status", 8'h02);
        check("post-reset irq", 32'(bus.interrupt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
